pixel_readout_seq: RTL and testbench

Digital sequencer that drives the analog pixel front-end through its per-photodiode readout cycle: select, reset, integrate, sample and single-slope conversion. It sits between the Wishbone/LA control logic and the analog system macro. It owns the 12 photodiode switch pairs, the sw/sh strobes and the one-hot transmission-gate routing. It returns one conversion word per enabled photodiode.

---
 rtl/pixseq_pkg.sv | 29 ++
 rtl/pixseq_next_pix.sv | 27 ++
 rtl/pixel_readout_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pixel_readout_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixseq_pkg.sv
// Shared types and constants for the pixel readout sequencer.
// Holds the state enum, TGate one-hot codes and default sizes.
package pixseq_pkg;

    localparam int NPIX_DEF  = 12;
    localparam int CNT_W_DEF = 8;
    localparam int TMR_W_DEF = 16;
    localparam int IDX_W     = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL,
        S_RST,
        S_INT,
        S_SMP,
        S_CONV,
        S_STORE,
        S_NEXT,
        S_DONE
    } state_e;

    // TGate routing, bit order {vref_cmp, ota_sh, cmp_out, sh_out, ota_out}
    localparam logic [4:0] TG_OTA_OUT  = 5'b00001;
    localparam logic [4:0] TG_SH_OUT   = 5'b00010;
    localparam logic [4:0] TG_CMP_OUT  = 5'b00100;
    localparam logic [4:0] TG_OTA_SH   = 5'b01000;
    localparam logic [4:0] TG_VREF_CMP = 5'b10000;

endpackage

// File: rtl/pixseq_next_pix.sv
// Combinational search for the lowest set mask bit above idx_i
// (or from bit 0 when first_i). Ports: mask_i, idx_i, first_i -> found_o, idx_o.
module pixseq_next_pix
    import pixseq_pkg::*;
#(
    parameter int NPIX = NPIX_DEF
) (
    input  logic [NPIX-1:0]  mask_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             first_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Descending scan: the last hit written is the lowest qualifying bit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NPIX - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || i > int'(idx_i))) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pixel_readout_seq.sv
// Per-photodiode readout sequencer: select, reset, integrate, sample, convert.
// In: start/abort, mask, phase lengths, cmp_i. Out: switches, strobes,
// tg_sel, data/valid, pix_idx, busy, done. PIXSEQ_CONT_EN adds cont_i.
module pixel_readout_seq
    import pixseq_pkg::*;
#(
    parameter int NPIX  = NPIX_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
`ifdef PIXSEQ_CONT_EN
    input  logic             cont_i,
`endif
    input  logic [NPIX-1:0]  pix_mask_i,
    input  logic [TMR_W-1:0] t_rst_i,
    input  logic [TMR_W-1:0] t_int_i,
    input  logic [TMR_W-1:0] t_sh_i,
    input  logic             cmp_i,
    output logic [NPIX-1:0]  pd_a_o,
    output logic [NPIX-1:0]  pd_b_o,
    output logic             sw1_o,
    output logic             sw2_o,
    output logic             sh_o,
    output logic             sh_cmp_o,
    output logic             sh_rst_o,
    output logic [4:0]       tg_sel_o,
    output logic [CNT_W-1:0] data_o,
    output logic             data_valid_o,
    output logic [IDX_W-1:0] pix_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NPIX-1:0]  mask_q, mask_d;
    logic [TMR_W-1:0] t_rst_q, t_rst_d, t_int_q, t_int_d;
    logic [TMR_W-1:0] t_sh_q, t_sh_d, tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, data_q, data_d;
    logic             cmp_s1_q, cmp_s2_q;
    logic             cont, launch;

    logic [NPIX-1:0]  pd_a_q, pd_a_d, pd_b_q, pd_b_d;
    logic [4:0]       tg_q, tg_d;
    logic [IDX_W-1:0] pix_q, pix_d;
    logic sw1_q, sw1_d, sw2_q, sw2_d, sh_q, sh_d;
    logic sh_cmp_q, sh_cmp_d, sh_rst_q, sh_rst_d;
    logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic [NPIX-1:0]  srch_mask;
    logic             srch_first, srch_found;
    logic [IDX_W-1:0] srch_idx;

`ifdef PIXSEQ_CONT_EN
    assign cont = cont_i;
`else
    assign cont = 1'b0;
`endif

    // Frame start searches the incoming mask from bit 0; NEXT searches
    // the latched mask above the current index.
    assign srch_mask  = (state_q == S_NEXT) ? mask_q : pix_mask_i;
    assign srch_first = (state_q != S_NEXT);

    pixseq_next_pix #(.NPIX(NPIX)) u_next (
        .mask_i  (srch_mask),
        .idx_i   (idx_q),
        .first_i (srch_first),
        .found_o (srch_found),
        .idx_o   (srch_idx)
    );

    // Saturating increment: the conversion count never wraps.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // A programmed length of 0 behaves as 1.
    function automatic logic [TMR_W-1:0] len_m1(input logic [TMR_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        t_rst_d = t_rst_q;
        t_int_d = t_int_q;
        t_sh_d  = t_sh_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        launch  = 1'b0;
        unique case (state_q)
            S_IDLE: launch = start_i;
            S_SEL: begin
                state_d = S_RST;
                tmr_d   = len_m1(t_rst_q);
            end
            S_RST: begin
                if (tmr_q == '0) begin
                    state_d = S_INT;
                    tmr_d   = len_m1(t_int_q);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_INT: begin
                if (tmr_q == '0) begin
                    state_d = S_SMP;
                    tmr_d   = len_m1(t_sh_q);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SMP: begin
                if (tmr_q == '0) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_CONV: begin
                cnt_d = cnt_inc;
                // First CONV cycle ignores the comparator so a level
                // already high on entry reads as 2.
                if ((cmp_s2_q && cnt_q != '0) || cnt_inc == '1) begin
                    state_d = S_STORE;
                    data_d  = cnt_inc;
                end
            end
            S_STORE: state_d = S_NEXT;
            S_NEXT: begin
                if (srch_found) begin
                    state_d = S_SEL;
                    idx_d   = srch_idx;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cont) launch = 1'b1;
                else      state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            mask_d  = pix_mask_i;
            t_rst_d = t_rst_i;
            t_int_d = t_int_i;
            t_sh_d  = t_sh_i;
            idx_d   = srch_idx;
            state_d = srch_found ? S_SEL : S_DONE;
        end
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            data_d  = '0;
        end
    end

    // Outputs are decoded from the next state so every output is a flop.
    always_comb begin
        pd_a_d   = '0;
        pd_b_d   = '1;
        tg_d     = TG_OTA_OUT;
        sw1_d    = 1'b0;
        sw2_d    = 1'b0;
        sh_d     = 1'b0;
        sh_cmp_d = 1'b0;
        sh_rst_d = 1'b0;
        valid_d  = (state_d == S_STORE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        pix_d    = (state_d == S_IDLE) ? '0 : idx_d;
        unique case (state_d)
            S_RST: begin
                sh_rst_d = 1'b1;
                sw1_d    = 1'b1;
            end
            S_INT: begin
                sw2_d = 1'b1;
                tg_d  = TG_OTA_SH;
            end
            S_SMP: begin
                sh_d = 1'b1;
                tg_d = TG_SH_OUT;
            end
            S_CONV: begin
                sh_cmp_d = 1'b1;
                tg_d     = TG_CMP_OUT;
            end
            default: ;
        endcase
        if (state_d inside {S_SEL, S_RST, S_INT, S_SMP, S_CONV}) begin
            pd_a_d[idx_d] = 1'b1;
            pd_b_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            mask_q   <= '0;
            t_rst_q  <= '0;
            t_int_q  <= '0;
            t_sh_q   <= '0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            cmp_s1_q <= 1'b0;
            cmp_s2_q <= 1'b0;
            pd_a_q   <= '0;
            pd_b_q   <= '1;
            tg_q     <= TG_OTA_OUT;
            sw1_q    <= 1'b0;
            sw2_q    <= 1'b0;
            sh_q     <= 1'b0;
            sh_cmp_q <= 1'b0;
            sh_rst_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            t_rst_q  <= t_rst_d;
            t_int_q  <= t_int_d;
            t_sh_q   <= t_sh_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            cmp_s1_q <= cmp_i;
            cmp_s2_q <= cmp_s1_q;
            pd_a_q   <= pd_a_d;
            pd_b_q   <= pd_b_d;
            tg_q     <= tg_d;
            sw1_q    <= sw1_d;
            sw2_q    <= sw2_d;
            sh_q     <= sh_d;
            sh_cmp_q <= sh_cmp_d;
            sh_rst_q <= sh_rst_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pix_q    <= pix_d;
        end
    end

    assign pd_a_o       = pd_a_q;
    assign pd_b_o       = pd_b_q;
    assign tg_sel_o     = tg_q;
    assign sw1_o        = sw1_q;
    assign sw2_o        = sw2_q;
    assign sh_o         = sh_q;
    assign sh_cmp_o     = sh_cmp_q;
    assign sh_rst_o     = sh_rst_q;
    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign pix_idx_o    = pix_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_pixel_readout_seq.sv
// Directed bench for pixel_readout_seq: frame vectors table plus
// reset, abort, start/abort collision and continuous-mode sequences.
module tb_pixel_readout_seq;
    import pixseq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        cmp_i = 1'b0;
`ifdef PIXSEQ_CONT_EN
    logic        cont_i = 1'b0;
`endif
    logic [11:0] pix_mask_i = '0;
    logic [15:0] t_rst_i = '0;
    logic [15:0] t_int_i = '0;
    logic [15:0] t_sh_i = '0;
    logic [11:0] pd_a_o, pd_b_o;
    logic        sw1_o, sw2_o, sh_o, sh_cmp_o, sh_rst_o;
    logic [4:0]  tg_sel_o;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic [3:0]  pix_idx_o;
    logic        busy_o, done_o;

    pixel_readout_seq dut (
        .wb_clk_i     (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
`ifdef PIXSEQ_CONT_EN
        .cont_i       (cont_i),
`endif
        .pix_mask_i   (pix_mask_i),
        .t_rst_i      (t_rst_i),
        .t_int_i      (t_int_i),
        .t_sh_i       (t_sh_i),
        .cmp_i        (cmp_i),
        .pd_a_o       (pd_a_o),
        .pd_b_o       (pd_b_o),
        .sw1_o        (sw1_o),
        .sw2_o        (sw2_o),
        .sh_o         (sh_o),
        .sh_cmp_o     (sh_cmp_o),
        .sh_rst_o     (sh_rst_o),
        .tg_sel_o     (tg_sel_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .pix_idx_o    (pix_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // cmp_n: -1 never trips, 0 held high from start,
    // n>0 asserted before the edge beginning CONV cycle n.
    typedef struct {
        logic [11:0] mask;
        logic [15:0] tr;
        logic [15:0] ti;
        logic [15:0] ts;
        int          cmp_n;
        int          exp_data;
        int          exp_done;
    } vec_t;

    localparam int NV = 8;
    vec_t vt[NV];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int out_errs();
        int e;
        e = 0;
        if (!$onehot(tg_sel_o)) e++;
        if (pd_a_o != '0 && (!$onehot(pd_a_o) || pd_b_o != ~pd_a_o)) e++;
        if (pd_a_o == '0 && pd_b_o != 12'hfff) e++;
        if (sw1_o && (!sh_rst_o || tg_sel_o != TG_OTA_OUT || pd_a_o == '0)) e++;
        if (sw2_o && (tg_sel_o != TG_OTA_SH || pd_a_o == '0)) e++;
        if (sh_o && (tg_sel_o != TG_SH_OUT || pd_a_o == '0)) e++;
        if (sh_cmp_o && (tg_sel_o != TG_CMP_OUT || pd_a_o == '0)) e++;
        if ((data_valid_o || done_o) && pd_a_o != '0) e++;
        return e;
    endfunction

    int nval, derr, done_at, conv_k, dmis, imis, ndone, found;
    int exp_idx[$];

    initial begin
        vt[0] = '{12'h001, 16'd4, 16'd4, 16'd4, 10, 12, 28};
        vt[1] = '{12'h841, 16'd2, 16'd3, 16'd1, 3, 5, 43};
        vt[2] = '{12'h000, 16'd4, 16'd4, 16'd4, -1, 0, 1};
        vt[3] = '{12'h001, 16'd1, 16'd1, 16'd1, -1, 255, 262};
        vt[4] = '{12'h002, 16'd0, 16'd0, 16'd0, 1, 3, 10};
        vt[5] = '{12'h800, 16'd5, 16'd0, 16'd2, 253, 255, 267};
        vt[6] = '{12'h010, 16'd1, 16'd1, 16'd1, 252, 254, 261};
        vt[7] = '{12'h001, 16'd1, 16'd1, 16'd1, 0, 2, 9};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pd_a", pd_a_o, 12'h000);
        chk("rst_pd_b", pd_b_o, 12'hfff);
        chk("rst_tg", tg_sel_o, 5'b00001);
        chk("rst_data", data_o, 0);
        chk("rst_idx", pix_idx_o, 0);
        chk("rst_flags", {busy_o, done_o, data_valid_o, sw1_o,
                          sw2_o, sh_o, sh_cmp_o, sh_rst_o}, 0);
        rst_n = 1'b1;
        tick();

        // start coincident with abort in IDLE: start wins
        pix_mask_i = 12'h001;
        t_rst_i = 16'd4; t_int_i = 16'd4; t_sh_i = 16'd4;
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_wins_busy", busy_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_sel_busy", busy_o, 0);
        tick();

        for (int v = 0; v < NV; v++) begin
            pix_mask_i = vt[v].mask;
            t_rst_i = vt[v].tr; t_int_i = vt[v].ti; t_sh_i = vt[v].ts;
            cmp_i = (vt[v].cmp_n == 0);
            exp_idx.delete();
            for (int b = 0; b < 12; b++)
                if (vt[v].mask[b]) exp_idx.push_back(b);
            nval = 0; derr = 0; done_at = -1;
            conv_k = 0; dmis = 0; imis = 0;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            for (int c = 1; c <= 2000; c++) begin
                derr += out_errs();
                if (!busy_o) derr++;
                if (sh_cmp_o) begin
                    if (vt[v].cmp_n > 0 && conv_k == vt[v].cmp_n - 1)
                        cmp_i = 1'b1;
                    conv_k++;
                end else begin
                    conv_k = 0;
                end
                if (data_valid_o) begin
                    if (int'(data_o) != vt[v].exp_data) dmis++;
                    if (nval >= exp_idx.size()) imis++;
                    else if (int'(pix_idx_o) != exp_idx[nval]) imis++;
                    nval++;
                    if (vt[v].cmp_n != 0) cmp_i = 1'b0;
                end
                if (done_o) begin
                    done_at = c;
                    break;
                end
                tick();
            end
            cmp_i = 1'b0;
            chk($sformatf("v%0d_done_cycle", v), done_at, vt[v].exp_done);
            chk($sformatf("v%0d_nvalid", v), nval, exp_idx.size());
            chk($sformatf("v%0d_data_err", v), dmis, 0);
            chk($sformatf("v%0d_order_err", v), imis, 0);
            chk($sformatf("v%0d_out_err", v), derr, 0);
            tick();
            chk($sformatf("v%0d_idle", v), {busy_o, done_o}, 0);
            if (vt[v].mask == '0)
                chk("v_mask0_pd_b", pd_b_o, 12'hfff);
        end

        // Abort mid-INT of the second photodiode
        pix_mask_i = 12'h003;
        t_rst_i = 16'd4; t_int_i = 16'd4; t_sh_i = 16'd4;
        cmp_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (sw2_o && pix_idx_o == 4'd1) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("abort_reach_int2", found, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        cmp_i = 1'b0;
        chk("abort_pd_a", pd_a_o, 12'h000);
        chk("abort_pd_b", pd_b_o, 12'hfff);
        chk("abort_tg", tg_sel_o, 5'b00001);
        chk("abort_data", data_o, 0);
        chk("abort_idx", pix_idx_o, 0);
        chk("abort_flags", {busy_o, done_o, data_valid_o, sw1_o,
                            sw2_o, sh_o, sh_cmp_o, sh_rst_o}, 0);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (done_o || data_valid_o || busy_o) ndone++;
            tick();
        end
        chk("abort_quiet", ndone, 0);

`ifdef PIXSEQ_CONT_EN
        pix_mask_i = 12'h003;
        t_rst_i = 16'd1; t_int_i = 16'd1; t_sh_i = 16'd1;
        cmp_i = 1'b1;
        cont_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ndone = 0; nval = 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy_o) break;
            if (data_valid_o) nval++;
            if (done_o) begin
                ndone++;
                if (ndone == 2) cont_i = 1'b0;
            end
            tick();
        end
        cmp_i = 1'b0;
        chk("cont_dones", ndone, 2);
        chk("cont_valids", nval, 4);
        chk("cont_idle", busy_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
